// File: rtl/button_pio_pkg.sv
// Shared types and constants for the button PIO sequencer.
package button_pio_pkg;

    // Sequencer states, in service order
    typedef enum logic [3:0] {
        ST_INIT_MASK,
        ST_IDLE,
        ST_RD_CAP,
        ST_WAIT_CAP,
        ST_CLR_CAP,
        ST_RD_DATA,
        ST_WAIT_DATA,
        ST_PUSH,
        ST_HOLDOFF
    } state_t;

    // PIO register map
    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    // Event word: {level[3:0], edges[3:0]}
    localparam int EVT_W = 8;

    // Writing all ones clears every edge-capture bit
    localparam logic [3:0] EDGE_CLR_ALL = 4'hF;

endpackage

// File: rtl/button_pio_sequencer_fifo.sv
// Registered event FIFO: a push is visible at the head one cycle later.
module button_evt_fifo
    import button_pio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [EVT_W-1:0]         push_data,
    input  logic                     pop,
    output logic [EVT_W-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [EVT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Accept a push into a full FIFO only when a pop frees a slot in the same cycle
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/button_pio_sequencer.sv
// Avalon-MM master that services the button PIO interrupt and queues events.
module button_pio_sequencer
    import button_pio_pkg::*;
#(
    parameter logic [3:0] IRQ_MASK       = 4'hF,
    parameter int         HOLDOFF_CYCLES = 500000,
    parameter int         FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [1:0]                    pio_address,
    output logic                          pio_chipselect,
    output logic                          pio_write_n,
    output logic [31:0]                   pio_writedata,
    input  logic [31:0]                   pio_readdata,
    input  logic                          pio_irq,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [EVT_W-1:0]              evt_data,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          ovf,
    input  logic                          ovf_clr,
    output logic                          busy
);

    localparam int HOLD_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD =
        (HOLDOFF_CYCLES > 0) ? HOLD_W'(HOLDOFF_CYCLES - 1) : '0;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]        edges_q, edges_d;
    logic [3:0]        level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              cs_q, cs_d;
    logic              write_n_q, write_n_d;
    logic [1:0]        addr_q, addr_d;
    logic [3:0]        wdata_q, wdata_d;
    logic              push_req;
    logic              fifo_full, fifo_empty, pop_ok, drop;
    logic              unused_rd_hi;

    // The PIO only implements four bits; the upper read bits carry nothing
    assign unused_rd_hi = ^pio_readdata[31:4];

    assign pio_chipselect = cs_q;
    assign pio_write_n    = write_n_q;
    assign pio_address    = addr_q;
    assign pio_writedata  = {28'h0, wdata_q};
    assign busy           = (state_q != ST_IDLE);
    assign evt_valid      = !fifo_empty;
    assign ovf            = ovf_q;
    assign pop_ok         = evt_valid && evt_ready;
    assign drop           = push_req && fifo_full && !pop_ok;

    // Next-state, hold-off countdown and captured edge/level words
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        edges_d    = edges_q;
        level_d    = level_q;
        push_req   = 1'b0;
        case (state_q)
            ST_INIT_MASK: state_d = ST_IDLE;
            ST_IDLE:      if (pio_irq) state_d = ST_RD_CAP;
            ST_RD_CAP:    state_d = ST_WAIT_CAP;
            ST_WAIT_CAP: begin
                edges_d = pio_readdata[3:0];
                state_d = ST_CLR_CAP;
            end
            ST_CLR_CAP:   state_d = ST_RD_DATA;
            ST_RD_DATA:   state_d = ST_WAIT_DATA;
            ST_WAIT_DATA: begin
                level_d = pio_readdata[3:0];
                state_d = ST_PUSH;
            end
            ST_PUSH: begin
                // A spurious irq (no captured edge) still gets the hold-off
                push_req = (edges_q != 4'h0);
                if (HOLDOFF_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_HOLDOFF;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt_q == '0) state_d = ST_IDLE;
                else                  hold_cnt_d = hold_cnt_q - 1'b1;
            end
            default:      state_d = ST_INIT_MASK;
        endcase
    end

    // Bus cycle for the coming cycle; the mask write issued from INIT_MASK
    // lands in the first IDLE cycle so the reset cycle itself stays quiet
    always_comb begin
        cs_d      = 1'b0;
        write_n_d = 1'b1;
        addr_d    = 2'd0;
        wdata_d   = 4'h0;
        if (state_q == ST_INIT_MASK) begin
            cs_d      = 1'b1;
            write_n_d = 1'b0;
            addr_d    = PIO_ADDR_MASK;
            wdata_d   = IRQ_MASK;
        end else begin
            case (state_d)
                ST_RD_CAP: begin
                    cs_d   = 1'b1;
                    addr_d = PIO_ADDR_EDGE;
                end
                ST_CLR_CAP: begin
                    cs_d      = 1'b1;
                    write_n_d = 1'b0;
                    addr_d    = PIO_ADDR_EDGE;
                    wdata_d   = EDGE_CLR_ALL;
                end
                ST_RD_DATA: begin
                    cs_d   = 1'b1;
                    addr_d = PIO_ADDR_DATA;
                end
                default: ;
            endcase
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps it set
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT_MASK;
            hold_cnt_q <= '0;
            ovf_q      <= 1'b0;
            cs_q       <= 1'b0;
            write_n_q  <= 1'b1;
            addr_q     <= 2'd0;
            wdata_q    <= 4'h0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            ovf_q      <= ovf_d;
            cs_q       <= cs_d;
            write_n_q  <= write_n_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Captured event fields
    always_ff @(posedge clk) begin
        edges_q <= edges_d;
        level_q <= level_d;
    end

    button_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data ({level_q, edges_q}),
        .pop       (evt_ready),
        .head_data (evt_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (evt_count)
    );

endmodule

// File: tb/tb_button_pio_sequencer.sv
// Directed bench for button_pio_sequencer with a behavioural button PIO.
module tb_button_pio_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata = 32'h0;
    logic        pio_irq;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [7:0]  evt_data;
    logic [2:0]  evt_count;
    logic        ovf;
    logic        ovf_clr = 1'b0;
    logic        busy;

    // PIO model state
    logic [3:0]  edge_cap = 4'h0;
    logic [3:0]  mask_r = 4'h0;
    logic [3:0]  level = 4'h0;
    logic [3:0]  inj = 4'h0;
    logic        irq_force = 1'b0;
    logic [7:0]  trace [$];

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    button_pio_sequencer #(
        .IRQ_MASK       (4'hF),
        .HOLDOFF_CYCLES (10),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .pio_irq        (pio_irq),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_data       (evt_data),
        .evt_count      (evt_count),
        .ovf            (ovf),
        .ovf_clr        (ovf_clr),
        .busy           (busy)
    );

    // Button PIO: registered reads, clear has priority over a new edge
    always @(posedge clk) begin
        if (pio_chipselect && pio_write_n) begin
            case (pio_address)
                2'd0:    pio_readdata <= {28'h0, level};
                2'd2:    pio_readdata <= {28'h0, mask_r};
                2'd3:    pio_readdata <= {28'h0, edge_cap};
                default: pio_readdata <= 32'h0;
            endcase
        end
        if (pio_chipselect && !pio_write_n && pio_address == 2'd2)
            mask_r <= pio_writedata[3:0];
        if (pio_chipselect && !pio_write_n && pio_address == 2'd3)
            edge_cap <= 4'h0;
        else
            edge_cap <= edge_cap | inj;
    end

    assign pio_irq = (|(edge_cap & mask_r)) | irq_force;

    // Bus trace: {write_n, 0, address, writedata[3:0]}
    always @(posedge clk) begin
        if (pio_chipselect)
            trace.push_back({pio_write_n, 1'b0, pio_address, pio_writedata[3:0]});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present an edge for one posedge; returns at the negedge after capture
    task automatic inject(input logic [3:0] v);
        inj = v;
        tick(1);
        inj = 4'h0;
    endtask

    function automatic logic [7:0] tr_at(input int i);
        if (i < trace.size()) return trace[i];
        return 8'hEE;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        tick(1);
        while (busy && n < 200) begin
            tick(1);
            n++;
        end
        chk("idle_timeout", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_cs", {31'h0, pio_chipselect}, 32'h0);
        chk("rst_wn", {31'h0, pio_write_n}, 32'h1);
        chk("rst_addr", {30'h0, pio_address}, 32'h0);
        chk("rst_wdata", pio_writedata, 32'h0);
        chk("rst_valid", {31'h0, evt_valid}, 32'h0);
        chk("rst_count", {29'h0, evt_count}, 32'h0);
        chk("rst_ovf", {31'h0, ovf}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h1);
        reset = 1'b0;
        tick(1);
        chk("init_cs", {31'h0, pio_chipselect}, 32'h1);
        chk("init_wn", {31'h0, pio_write_n}, 32'h0);
        chk("init_addr", {30'h0, pio_address}, 32'h2);
        chk("init_wdata", pio_writedata, 32'h0000000F);
        chk("init_busy", {31'h0, busy}, 32'h0);
        tick(1);
        chk("init_cs_off", {31'h0, pio_chipselect}, 32'h0);

        // Basic event: edges 0101, level 0001
        level = 4'b0001;
        trace.delete();
        inject(4'b0101);
        tick(6);
        chk("lat6_valid", {31'h0, evt_valid}, 32'h0);
        tick(1);
        chk("lat7_valid", {31'h0, evt_valid}, 32'h1);
        chk("ev1_data", {24'h0, evt_data}, 32'h15);
        chk("ev1_count", {29'h0, evt_count}, 32'h1);
        chk("trace_len", trace.size(), 32'd3);
        chk("trace0", {24'h0, tr_at(0)}, 32'hB0);
        chk("trace1", {24'h0, tr_at(1)}, 32'h3F);
        chk("trace2", {24'h0, tr_at(2)}, 32'h80);
        tick(9);
        chk("hold_busy", {31'h0, busy}, 32'h1);
        tick(1);
        chk("hold_done", {31'h0, busy}, 32'h0);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("pop1_valid", {31'h0, evt_valid}, 32'h0);
        chk("pop1_count", {29'h0, evt_count}, 32'h0);

        // Spurious irq: no captured edges
        irq_force = 1'b1;
        tick(1);
        irq_force = 1'b0;
        tick(6);
        chk("spur_count", {29'h0, evt_count}, 32'h0);
        chk("spur_valid", {31'h0, evt_valid}, 32'h0);
        chk("spur_busy", {31'h0, busy}, 32'h1);
        tick(9);
        chk("spur_hold", {31'h0, busy}, 32'h1);
        tick(1);
        chk("spur_idle", {31'h0, busy}, 32'h0);

        // Second edge during hold-off is serviced after it
        level = 4'b0011;
        inject(4'b0010);
        tick(8);
        level = 4'b1000;
        inject(4'b1000);
        tick(7);
        chk("ho_busy16", {31'h0, busy}, 32'h1);
        chk("ho_count1", {29'h0, evt_count}, 32'h1);
        tick(1);
        chk("ho_idle17", {31'h0, busy}, 32'h0);
        tick(1);
        chk("ho_busy18", {31'h0, busy}, 32'h1);
        tick(5);
        chk("ho_count23", {29'h0, evt_count}, 32'h1);
        tick(1);
        chk("ho_count24", {29'h0, evt_count}, 32'h2);
        chk("ho_head", {24'h0, evt_data}, 32'h32);
        evt_ready = 1'b1;
        tick(1);
        chk("ho_head2", {24'h0, evt_data}, 32'h88);
        chk("ho_cnt_pop", {29'h0, evt_count}, 32'h1);
        tick(1);
        evt_ready = 1'b0;
        chk("ho_empty", {31'h0, evt_valid}, 32'h0);
        wait_idle();

        // Edge arriving in the CLR_CAP cycle is lost
        level = 4'b0110;
        inject(4'b0001);
        tick(3);
        inject(4'b0100);
        tick(3);
        chk("clr_count", {29'h0, evt_count}, 32'h1);
        chk("clr_head", {24'h0, evt_data}, 32'h61);
        tick(23);
        chk("clr_no_more", {29'h0, evt_count}, 32'h1);
        chk("clr_idle", {31'h0, busy}, 32'h0);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("clr_drain", {29'h0, evt_count}, 32'h0);

        // Overflow with consumer stalled
        for (int i = 0; i < 5; i++) begin
            level = 4'(8 + i);
            inject(4'(i + 1));
            wait_idle();
            if (i == 3) begin
                chk("full_count", {29'h0, evt_count}, 32'h4);
                chk("full_no_ovf", {31'h0, ovf}, 32'h0);
            end
        end
        chk("ovf_count", {29'h0, evt_count}, 32'h4);
        chk("ovf_set", {31'h0, ovf}, 32'h1);
        chk("ovf_head", {24'h0, evt_data}, 32'h81);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", {31'h0, ovf}, 32'h0);

        // Push and pop together on a full FIFO
        level = 4'hC;
        inject(4'h6);
        tick(6);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("pp_count", {29'h0, evt_count}, 32'h4);
        chk("pp_ovf", {31'h0, ovf}, 32'h0);
        chk("pp_head", {24'h0, evt_data}, 32'h92);
        wait_idle();

        // Overflow and clear in the same cycle: set wins
        level = 4'hD;
        inject(4'h7);
        tick(6);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("setwin_ovf", {31'h0, ovf}, 32'h1);
        chk("setwin_cnt", {29'h0, evt_count}, 32'h4);
        wait_idle();

        // Reset during WAIT_CAP
        inject(4'h1);
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mrst_cs", {31'h0, pio_chipselect}, 32'h0);
        chk("mrst_count", {29'h0, evt_count}, 32'h0);
        chk("mrst_valid", {31'h0, evt_valid}, 32'h0);
        chk("mrst_ovf", {31'h0, ovf}, 32'h0);
        chk("mrst_busy", {31'h0, busy}, 32'h1);
        tick(1);
        chk("mrst_mask_cs", {31'h0, pio_chipselect}, 32'h1);
        chk("mrst_mask_wn", {31'h0, pio_write_n}, 32'h0);
        chk("mrst_mask_addr", {30'h0, pio_address}, 32'h2);
        chk("mrst_mask_data", pio_writedata, 32'h0000000F);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
